draw_wall_column: RTL
=====================

DRAW_WALL_COLUMN -- requirements
Module: draw_wall_column

Interface
REQ-001 SHALL have parameter SCREEN_H, default 120, number of screen rows.
REQ-002 SHALL have parameter CEIL_COLOUR, default 18'h0_0FC0, ceiling RGB666.
REQ-003 SHALL have parameter FLOOR_COLOUR, default 18'h1_0410, floor RGB666.
REQ-004 SHALL have port clock, input, 1, global clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, one-cycle request to draw a column.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when the column is complete.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start until done is asserted.
REQ-009 SHALL have port x, input, 8, screen column; sampled with start.
REQ-010 SHALL have port wall_height, input, 7, wall slice height in pixels; sampled with start.
REQ-011 SHALL have port wall_colour, input, 18, wall RGB666; sampled with start.
REQ-012 SHALL have ports vga_x (output, 8), vga_y (output, 7), vga_colour (output, 18) and vga_write (output, 1), carrying the pixel write to the VGA adapter.

Function
REQ-013 SHALL use FSM states IDLE, SETUP, CEIL, WALL, FLOOR and DONE.
- IDLE->SETUP on start.
- SETUP->CEIL if top>0, else WALL if h>0, else FLOOR.
- CEIL->WALL at y=top-1.
- WALL->FLOOR at y=bottom.
- FLOOR->DONE at y=SCREEN_H-1.
- DONE->IDLE.
REQ-014 SHALL latch x, wall_height and wall_colour in IDLE when start=1; input changes afterwards SHALL NOT affect the column in progress.
REQ-015 SHALL clamp h=min(wall_height,SCREEN_H), then compute top=(SCREEN_H-h)>>1 and bottom=top+h-1, in SETUP.
REQ-016 SHALL issue exactly one pixel write per cycle in CEIL, WALL and FLOOR, with y incrementing from 0.
REQ-017 SHALL hold vga_x at the latched x during all writes.
REQ-018 SHALL set vga_colour to CEIL_COLOUR, wall_colour or FLOOR_COLOUR according to the current state.
REQ-019 SHALL register all vga_* outputs, so a write is visible in the cycle after the state that produced it.
REQ-020 SHALL give the following latency: start at cycle 0, first vga_write at cycle 2, last write at cycle SCREEN_H+1, done at cycle SCREEN_H+2.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL accept a start asserted in the same cycle as done only on the following IDLE cycle.
REQ-023 SHALL make h=0 produce no WALL writes and h>=SCREEN_H produce no CEIL or FLOOR writes.
REQ-024 SHALL hold vga_write=0 in IDLE, SETUP and DONE.

Reset
REQ-025 SHALL, on reset, enter IDLE and clear done, busy, vga_write, vga_x, vga_y and vga_colour to 0.
REQ-026 SHALL, if reset is asserted mid-column, abort the column with no further writes and no done pulse.

Configuration
REQ-027 SHALL behave as in REQ-013..REQ-024 when DRAW_WALL_COLUMN_FLOOR_CEIL_EN is defined, drawing all SCREEN_H rows.
REQ-028 SHALL, when DRAW_WALL_COLUMN_FLOOR_CEIL_EN is undefined:
- omit CEIL and FLOOR;
- write only rows top..bottom;
- go SETUP->DONE when h=0, producing zero writes with done at cycle 2.

Structure
REQ-029 SHALL take SCREEN_W=160, SCREEN_H=120, COLOUR_W=18 and the FSM state encoding from the shared package doom58_pkg.
REQ-030 SHALL compute top/bottom in a combinational sub-module column_bounds, instantiated once.

Verification
REQ-031 SHALL cover: x=5, h=40, colour=18'h3FFFF -> rows 0-39 CEIL_COLOUR, rows 40-79 wall, rows 80-119 FLOOR_COLOUR; 120 writes; done at cycle 122.
REQ-032 SHALL cover: h=0 -> 60 ceiling writes and 60 floor writes; with the macro undefined, zero writes and done at cycle 2.
REQ-033 SHALL cover: h=127 -> clamped to 120; 120 wall writes; no ceiling or floor writes.
REQ-034 SHALL cover: second start at cycle 50 with different x -> ignored; all writes keep the original x.
REQ-035 SHALL cover: reset at cycle 30 -> vga_write=0 from cycle 31; no done; a fresh start afterwards completes normally.
REQ-036 SHALL cover: start asserted on the done cycle -> ignored; a start one cycle later is accepted.

Source files
------------

// File: rtl/doom58_pkg.sv
// rtl/doom58_pkg.sv - shared screen geometry, colour width and column FSM encoding
package doom58_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CEIL  = 3'd2,
        WALL  = 3'd3,
        FLOOR = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/draw_wall_column_if.sv
// rtl/draw_wall_column_if.sv - pixel write bus towards the VGA adapter
// vga_x      : screen column of the write
// vga_y      : screen row of the write
// vga_colour : RGB666 pixel colour
// vga_write  : write strobe, one pixel per cycle while high
// master drives the bus (draw_wall_column), slave receives it (VGA adapter).
interface draw_wall_column_if;
    import doom58_pkg::*;

    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;

    modport master (output vga_x, vga_y, vga_colour, vga_write);
    modport slave  (input  vga_x, vga_y, vga_colour, vga_write);

endinterface

// File: rtl/column_bounds.sv
// rtl/column_bounds.sv - clamps the wall height and derives the wall's top and bottom rows
// wall_height : requested slice height in pixels
// h           : height clamped to SCREEN_ROWS
// top         : first wall row, slice centred vertically
// bottom      : last wall row (top+h-1; wraps to top-1 when h is 0, callers test h first)
module column_bounds #(
    parameter int SCREEN_ROWS = 120
) (
    input  logic [6:0] wall_height,
    output logic [6:0] h,
    output logic [6:0] top,
    output logic [6:0] bottom
);

    localparam logic [6:0] ROWS = 7'(SCREEN_ROWS);

    always_comb begin
        h      = (wall_height > ROWS) ? ROWS : wall_height;
        top    = (ROWS - h) >> 1;
        bottom = top + h - 7'd1;
    end

endmodule

// File: rtl/draw_wall_column.sv
// rtl/draw_wall_column.sv - draws one screen column (ceiling, wall slice, floor) as pixel writes
// clock, reset            : rising-edge clock, synchronous active-high reset
// start                   : one-cycle draw request, x/wall_height/wall_colour sampled with it
// done                    : one-cycle pulse when the column is finished
// busy                    : high from the cycle after an accepted start until done
// vga                     : registered pixel write bus (draw_wall_column_if.master)
// DRAW_WALL_COLUMN_FLOOR_CEIL_EN : when defined, ceiling and floor rows are drawn as well,
//                           covering all SCREEN_H rows; otherwise only rows top..bottom.
module draw_wall_column #(
    parameter int                                SCREEN_H     = doom58_pkg::SCREEN_H,
    parameter logic [doom58_pkg::COLOUR_W-1:0]   CEIL_COLOUR  = 18'h0_0FC0,
    parameter logic [doom58_pkg::COLOUR_W-1:0]   FLOOR_COLOUR = 18'h1_0410
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    output logic                              done,
    output logic                              busy,
    input  logic [7:0]                        x,
    input  logic [6:0]                        wall_height,
    input  logic [doom58_pkg::COLOUR_W-1:0]   wall_colour,
    draw_wall_column_if.master                vga
);

    import doom58_pkg::state_t, doom58_pkg::IDLE, doom58_pkg::SETUP, doom58_pkg::CEIL,
           doom58_pkg::WALL, doom58_pkg::FLOOR, doom58_pkg::DONE;

    localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

    state_t                            state, state_next;
    logic [7:0]                        x_q;
    logic [6:0]                        height_q;
    logic [doom58_pkg::COLOUR_W-1:0]   colour_q;
    logic [6:0]                        y, y_next;
    logic [6:0]                        h, top, bottom;
    logic                              accept;
    logic                              pix_write;
    logic [doom58_pkg::COLOUR_W-1:0]   pix_colour;

    // Bounds come from the latched height, so they stay stable for the whole column.
    column_bounds #(.SCREEN_ROWS(SCREEN_H)) u_bounds (
        .wall_height (height_q),
        .h           (h),
        .top         (top),
        .bottom      (bottom)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        y_next     = y;
        accept     = 1'b0;
        pix_write  = 1'b0;
        pix_colour = colour_q;
        case (state)
            IDLE: begin
                // done is high in the first IDLE cycle; a start then is deliberately dropped.
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
`ifdef DRAW_WALL_COLUMN_FLOOR_CEIL_EN
                y_next = 7'd0;
                if (top != 7'd0) begin
                    state_next = CEIL;
                end else if (h != 7'd0) begin
                    state_next = WALL;
                end else begin
                    state_next = FLOOR;
                end
`else
                y_next     = top;
                state_next = (h != 7'd0) ? WALL : DONE;
`endif
            end
`ifdef DRAW_WALL_COLUMN_FLOOR_CEIL_EN
            CEIL: begin
                pix_write  = 1'b1;
                pix_colour = CEIL_COLOUR;
                y_next     = y + 7'd1;
                // With no wall the ceiling runs straight into the floor.
                if (y == top - 7'd1) begin
                    state_next = (h != 7'd0) ? WALL : FLOOR;
                end
            end
`endif
            WALL: begin
                pix_write  = 1'b1;
                pix_colour = colour_q;
                y_next     = y + 7'd1;
                if (y == bottom) begin
`ifdef DRAW_WALL_COLUMN_FLOOR_CEIL_EN
                    state_next = (bottom == LAST_ROW) ? DONE : FLOOR;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef DRAW_WALL_COLUMN_FLOOR_CEIL_EN
            FLOOR: begin
                pix_write  = 1'b1;
                pix_colour = FLOOR_COLOUR;
                y_next     = y + 7'd1;
                if (y == LAST_ROW) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q            <= '0;
            height_q       <= '0;
            colour_q       <= '0;
            y              <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            vga.vga_write  <= 1'b0;
            vga.vga_x      <= '0;
            vga.vga_y      <= '0;
            vga.vga_colour <= '0;
        end else begin
            y <= y_next;
            if (accept) begin
                x_q      <= x;
                height_q <= wall_height;
                colour_q <= wall_colour;
            end
            done <= (state == DONE);
            if (accept) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            vga.vga_write <= pix_write;
            if (pix_write) begin
                vga.vga_x      <= x_q;
                vga.vga_y      <= y;
                vga.vga_colour <= pix_colour;
            end
        end
    end

endmodule
